// File: rtl/bus_serializer.sv
// rtl/bus_serializer.sv - framed serial transmitter: start, data LSB first, optional even parity, stop
module bus_serializer #(
    parameter int WIDTH     = 4,
    parameter int CLK_DIV   = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx,
    output logic             busy
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [BIT_W-1:0]   bit_q;
    logic [WIDTH-1:0]   shift_q;
    logic               parity_q;
    logic               tx_q;
    logic               busy_q;

    logic               bit_end;
    logic [WIDTH-1:0]   shifted;

    assign bit_end   = (div_q == DIV_W'(CLK_DIV - 1));
    assign shifted   = shift_q >> 1;
    assign din_ready = (state_q == IDLE);
    assign tx        = tx_q;
    assign busy      = busy_q;

    // tx is loaded one state ahead so the line changes on the same edge the state does
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (din_valid) begin
                state_q  <= START;
                shift_q  <= din;
                parity_q <= ^din;
                div_q    <= '0;
                bit_q    <= '0;
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
            end
        end else if (!bit_end) begin
            div_q <= div_q + DIV_W'(1);
        end else begin
            div_q <= '0;
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                end
                DATA: begin
                    if (bit_q == BIT_W'(WIDTH - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_q <= PARITY;
                            tx_q    <= parity_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bit_q   <= bit_q + BIT_W'(1);
                        shift_q <= shifted;
                        tx_q    <= shifted[0];
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_serializer.sv
// tb/tb_bus_serializer.sv - randomized bench with a frame-queue reference model for two serializer configurations
module tb_bus_serializer;
    localparam int DIV [2] = '{4, 1};
    localparam int PAR [2] = '{1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv [2];
    logic [3:0] dd [2];
    logic       tx_w [2];
    logic       busy_w [2];
    logic       rdy_w [2];

    int vectors     = 0;
    int miscompares = 0;

    // expected line value per cycle, one entry per clk cycle of a frame
    bit   mq [2][$];
    logic exp_tx [2]   = '{1'b1, 1'b1};
    logic exp_busy [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    bus_serializer #(.WIDTH(4), .CLK_DIV(4), .PARITY_EN(1)) u_dut0 (
        .clk(clk), .rst(rst), .din(dd[0]), .din_valid(dv[0]),
        .din_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
    );

    bus_serializer #(.WIDTH(4), .CLK_DIV(1), .PARITY_EN(0)) u_dut1 (
        .clk(clk), .rst(rst), .din(dd[1]), .din_valid(dv[1]),
        .din_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
    );

    task automatic check(string name, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic void push_frame(int i, logic [3:0] w);
        bit bits [$];
        bits.push_back(1'b0);
        for (int k = 0; k < 4; k++) bits.push_back(w[k]);
        if (PAR[i] != 0) bits.push_back(^w);
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int r = 0; r < DIV[i]; r++) mq[i].push_back(bits[b]);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                exp_tx[i]   <= 1'b1;
                exp_busy[i] <= 1'b0;
            end else begin
                if (!exp_busy[i] && dv[i]) push_frame(i, dd[i]);
                if (mq[i].size() > 0) begin
                    exp_tx[i]   <= mq[i].pop_front();
                    exp_busy[i] <= 1'b1;
                end else begin
                    exp_tx[i]   <= 1'b1;
                    exp_busy[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_tx%0d", i), tx_w[i], exp_tx[i]);
            check($sformatf("model_busy%0d", i), busy_w[i], exp_busy[i]);
            check($sformatf("model_ready%0d", i), rdy_w[i], !exp_busy[i]);
        end
    end

    task automatic send(int i, logic [3:0] w);
        @(negedge clk);
        dv[i] = 1'b1;
        dd[i] = w;
        @(posedge clk);
        #1 dv[i] = 1'b0;
    endtask

    task automatic expect_seq(int i, string name, logic [15:0] pat, int nbits);
        for (int k = nbits - 1; k >= 0; k--) begin
            for (int r = 0; r < DIV[i]; r++) begin
                @(negedge clk);
                check({name, "_tx"}, tx_w[i], pat[k]);
                check({name, "_busy"}, busy_w[i], 1'b1);
            end
        end
    endtask

    task automatic async_reset_check(string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check({name, "_tx"}, tx_w[i], 1'b1);
            check({name, "_busy"}, busy_w[i], 1'b0);
            check({name, "_ready"}, rdy_w[i], 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        dv = '{1'b0, 1'b0};
        dd = '{4'h0, 4'h0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        async_reset_check("rst_idle");
        repeat (2) @(negedge clk);

        send(0, 4'b1011);
        expect_seq(0, "t2", 16'b0110111, 7);
        @(negedge clk);
        check("t2_busy_end", busy_w[0], 1'b0);
        check("t2_ready_end", rdy_w[0], 1'b1);

        send(1, 4'b0110);
        expect_seq(1, "t3", 16'b001101, 6);
        @(negedge clk);
        check("t3_busy_end", busy_w[1], 1'b0);

        @(negedge clk);
        dv[0] = 1'b1;
        dd[0] = 4'h3;
        @(posedge clk);
        #1 dd[0] = 4'hC;
        repeat (28) @(negedge clk);
        @(negedge clk);
        check("t4_gap_busy", busy_w[0], 1'b0);
        check("t4_gap_ready", rdy_w[0], 1'b1);
        @(negedge clk);
        check("t4_second_busy", busy_w[0], 1'b1);
        check("t4_second_start", tx_w[0], 1'b0);
        dv[0] = 1'b0;
        repeat (30) @(negedge clk);

        send(0, 4'h5);
        fork
            expect_seq(0, "t5", 16'b0101001, 7);
            begin
                repeat (24) begin
                    @(negedge clk);
                    dv[0] = 1'($urandom);
                    dd[0] = 4'($urandom);
                    check("t5_ready", rdy_w[0], 1'b0);
                end
                dv[0] = 1'b0;
            end
        join
        repeat (3) @(negedge clk);

        send(0, 4'hF);
        repeat (8) @(negedge clk);
        async_reset_check("t6_rst");
        repeat (3) begin
            @(negedge clk);
            check("t6_idle_tx", tx_w[0], 1'b1);
        end
        send(0, 4'h0);
        expect_seq(0, "t6", 16'b0000001, 7);
        repeat (3) @(negedge clk);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                dv[i] = ($urandom_range(3) != 0);
                dd[i] = 4'($urandom);
            end
            if ($urandom_range(599) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        dv = '{1'b0, 1'b0};
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
